param_counter_bank: RTL and testbench

- Bank of NUM_CHANNELS independent up-counters. Width, step, wrap/saturate mode, reset value and terminal value are all set by parameters.
- Next-generation parametrised target for the VPI parameter examples. Benches override parameters at instantiation and read them back through vpiParameter / vpiParamAssign iteration.
- Benches then check that the bank's run-time behaviour matches the values read back.
- All six parameters are module parameters, never localparams, so that VPI iteration returns exactly six vpiParameter and six vpiParamAssign handles.

---
 rtl/param_counter_bank.sv | 89 ++++++++
 tb/tb_param_counter_bank.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/param_counter_bank.sv
// Bank of independent up-counters. Width, step, wrap/saturate behaviour,
// reset value and terminal count all come from module parameters.
module param_counter_bank #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned MODE         = 0,
  parameter int unsigned STEP         = 1,
  parameter int unsigned RESET_VALUE  = 0,
  parameter int unsigned MAX_VALUE    = 32'((64'd1 << WIDTH) - 64'd1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [NUM_CHANNELS-1:0]       en,
  input  logic [NUM_CHANNELS-1:0]       load,
  input  logic [NUM_CHANNELS*WIDTH-1:0] load_value,
  output logic [NUM_CHANNELS*WIDTH-1:0] count,
  output logic [NUM_CHANNELS-1:0]       at_max,
  output logic [NUM_CHANNELS-1:0]       wrapped,
  output logic                          any_at_max
);

  // Parameter legality is enforced at elaboration so a bad override never builds.
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 32) begin : g_chk_num_channels
    $fatal(1, "param_counter_bank: NUM_CHANNELS out of range");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
    $fatal(1, "param_counter_bank: WIDTH out of range");
  end
  if (MODE > 1) begin : g_chk_mode
    $fatal(1, "param_counter_bank: MODE must be 0 or 1");
  end
  if (MAX_VALUE < 1 || 64'(MAX_VALUE) > ((64'd1 << WIDTH) - 64'd1)) begin : g_chk_max
    $fatal(1, "param_counter_bank: MAX_VALUE out of range");
  end
  if (STEP < 1 || STEP > MAX_VALUE) begin : g_chk_step
    $fatal(1, "param_counter_bank: STEP out of range");
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_chk_reset_value
    $fatal(1, "param_counter_bank: RESET_VALUE above MAX_VALUE");
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] lv;

    assign lv = load_value[i*WIDTH +: WIDTH];
    // One extra bit so the overflow compare sees the untruncated sum.
    assign sum = {1'b0, cnt_q} + (WIDTH+1)'(STEP);

    always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clear) begin
        cnt_d = WIDTH'(RESET_VALUE);
      end else if (load[i]) begin
        cnt_d = (lv > WIDTH'(MAX_VALUE)) ? WIDTH'(MAX_VALUE) : lv;
      end else if (en[i]) begin
        if (sum <= (WIDTH+1)'(MAX_VALUE)) begin
          cnt_d = sum[WIDTH-1:0];
        end else if (MODE == 0) begin
          cnt_d  = WIDTH'(sum - (WIDTH+1)'(MAX_VALUE) - (WIDTH+1)'(1));
          wrap_d = 1'b1;
        end else begin
          cnt_d = WIDTH'(MAX_VALUE);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= WIDTH'(RESET_VALUE);
        wrap_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        wrap_q <= wrap_d;
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_q;
    assign wrapped[i]              = wrap_q;
    assign at_max[i]               = (cnt_q == WIDTH'(MAX_VALUE));
  end

  assign any_at_max = |at_max;

endmodule

// File: tb/tb_param_counter_bank.sv
// Randomised bench for param_counter_bank: three builds (wrap, saturate,
// nonzero reset value) share one stimulus stream and one behavioural model.
module tb_param_counter_bank;

  localparam int NC   = 2;
  localparam int W    = 4;
  localparam int NDUT = 3;
  localparam int MAXV = 12;
  localparam int STPV = 3;

  int mode_c [NDUT] = '{0, 1, 0};
  int rv_c   [NDUT] = '{0, 0, 5};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               clear;
  logic [NC-1:0]      en;
  logic [NC-1:0]      load;
  logic [NC*W-1:0]    load_value;

  logic [NC*W-1:0]    count_w   [NDUT];
  logic [NC-1:0]      at_max_w  [NDUT];
  logic [NC-1:0]      wrapped_w [NDUT];
  logic               any_w     [NDUT];

  param_counter_bank #(.NUM_CHANNELS(NC), .WIDTH(W), .MODE(0), .STEP(STPV),
                       .RESET_VALUE(0), .MAX_VALUE(MAXV)) u_wrap (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .load(load),
    .load_value(load_value), .count(count_w[0]), .at_max(at_max_w[0]),
    .wrapped(wrapped_w[0]), .any_at_max(any_w[0]));

  param_counter_bank #(.NUM_CHANNELS(NC), .WIDTH(W), .MODE(1), .STEP(STPV),
                       .RESET_VALUE(0), .MAX_VALUE(MAXV)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .load(load),
    .load_value(load_value), .count(count_w[1]), .at_max(at_max_w[1]),
    .wrapped(wrapped_w[1]), .any_at_max(any_w[1]));

  param_counter_bank #(.NUM_CHANNELS(NC), .WIDTH(W), .MODE(0), .STEP(STPV),
                       .RESET_VALUE(5), .MAX_VALUE(MAXV)) u_rv5 (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .load(load),
    .load_value(load_value), .count(count_w[2]), .at_max(at_max_w[2]),
    .wrapped(wrapped_w[2]), .any_at_max(any_w[2]));

  // ---------------- reference model + scoreboard ----------------
  int          exp_cnt [NDUT][NC];
  bit          exp_wr  [NDUT][NC];
  logic [NC*W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Counter rules stated directly as integer arithmetic.
  function automatic void model_step();
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < NC; c++) begin
        int s;
        exp_wr[d][c] = 1'b0;
        if (rst === 1'b1) exp_cnt[d][c] = rv_c[d];
        else if (clear) exp_cnt[d][c] = rv_c[d];
        else if (load[c]) begin
          s = int'(load_value[c*W +: W]);
          exp_cnt[d][c] = (s > MAXV) ? MAXV : s;
        end else if (en[c]) begin
          s = exp_cnt[d][c] + STPV;
          if (s <= MAXV) exp_cnt[d][c] = s;
          else if (mode_c[d] == 0) begin
            exp_cnt[d][c] = s - (MAXV + 1);
            exp_wr[d][c]  = 1'b1;
          end else exp_cnt[d][c] = MAXV;
        end
      end
    end
  endfunction

  task automatic compare();
    for (int d = 0; d < NDUT; d++) begin
      logic [NC*W-1:0] ec;
      logic [NC-1:0]   ew, em;
      ec = exp_q.pop_front();
      for (int c = 0; c < NC; c++) begin
        ew[c] = exp_wr[d][c];
        em[c] = (exp_cnt[d][c] == MAXV);
      end
      check($sformatf("count[d%0d]", d), count_w[d], ec);
      check($sformatf("wrapped[d%0d]", d), wrapped_w[d], ew);
      check($sformatf("at_max[d%0d]", d), at_max_w[d], em);
      check($sformatf("any_at_max[d%0d]", d), any_w[d], |em);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    for (int d = 0; d < NDUT; d++) begin
      logic [NC*W-1:0] e;
      for (int c = 0; c < NC; c++) e[c*W +: W] = W'(exp_cnt[d][c]);
      exp_q.push_back(e);
    end
    #1;
    compare();
  endtask

  task automatic drive(input logic r, input logic cl, input logic [NC-1:0] e,
                       input logic [NC-1:0] l, input logic [NC*W-1:0] lv);
    rst = r; clear = cl; en = e; load = l; load_value = lv;
  endtask

  int wrap_tab [6] = '{3, 6, 9, 12, 2, 5};
  int sat_tab  [6] = '{3, 6, 9, 12, 12, 12};

  initial begin
    // Reset with unknown strobes: rst must dominate.
    rst = 1'b1; clear = 1'b0; en = 'x; load = 'x; load_value = '0;
    tick();

    // Channel 0 counts for six cycles; channel 1 idles.
    drive(1'b0, 1'b0, 2'b01, 2'b00, '0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("wrap_seq", count_w[0][3:0], wrap_tab[k]);
      check("sat_seq", count_w[1][3:0], sat_tab[k]);
      check("wrap_pulse", wrapped_w[0][0], (k == 4) ? 1 : 0);
      check("ch1_idle", count_w[0][7:4], 0);
    end

    // Load beats en and is clamped to the terminal count.
    drive(1'b0, 1'b0, 2'b10, 2'b10, {4'd15, 4'd0});
    tick();
    check("load_clamp", count_w[0][7:4], 12);
    check("load_any_max", any_w[0], 1);

    // Clear beats load.
    drive(1'b0, 1'b1, 2'b00, 2'b01, {4'd0, 4'd7});
    tick();
    check("clear_rv5", count_w[2], {4'd5, 4'd5});

    // Reset mid-count with en and load asserted.
    drive(1'b1, 1'b0, 2'b00, 2'b00, '0);
    tick();
    drive(1'b0, 1'b0, 2'b01, 2'b00, '0);
    repeat (3) tick();
    check("pre_rst_nine", count_w[0][3:0], 9);
    drive(1'b1, 1'b0, 2'b01, 2'b01, {4'd0, 4'd11});
    tick();
    drive(1'b0, 1'b0, 2'b01, 2'b00, '0);
    tick();
    check("resume_rv5", count_w[2][3:0], 8);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      logic [NC-1:0]   re, rl;
      logic [NC*W-1:0] rlv;
      for (int c = 0; c < NC; c++) begin
        re[c] = ($urandom_range(0, 1) == 1);
        rl[c] = ($urandom_range(0, 4) == 0);
        rlv[c*W +: W] = W'($urandom_range(0, 15));
      end
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0, re, rl, rlv);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
